// File: rtl/triangle_raster_if.sv
// Bundle between the vertex-fetch pipe, the rasteriser and the framebuffer writer:
// triangle request, pixel stream with valid/ready, and status.
interface triangle_raster_if #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned COLOUR_WIDTH = 3,
    parameter int unsigned X_BITS       = 8,
    parameter int unsigned Y_BITS       = 7
);
    logic                    draw_en;
    logic [WIDTH-1:0]        ax, ay, bx, by, cx, cy;
    logic [COLOUR_WIDTH-1:0] colour;
    logic                    plot;
    logic [X_BITS-1:0]       px;
    logic [Y_BITS-1:0]       py;
    logic [COLOUR_WIDTH-1:0] pcolour;
    logic                    plot_ready;
    logic                    draw_done;
    logic                    busy;

    modport master (
        output draw_en, ax, ay, bx, by, cx, cy, colour, plot_ready,
        input  plot, px, py, pcolour, draw_done, busy
    );

    modport slave (
        input  draw_en, ax, ay, bx, by, cx, cy, colour, plot_ready,
        output plot, px, py, pcolour, draw_done, busy
    );
endinterface

// File: rtl/triangle_raster.sv
// Flat-shaded triangle rasteriser: bounding-box scan with incremental edge functions,
// one candidate pixel per clock, valid/ready pixel output and a single done pulse.
module triangle_raster #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned COLOUR_WIDTH = 3,
    parameter int signed   X_MAX        = 159,
    parameter int signed   Y_MAX        = 119,
    parameter int unsigned X_BITS       = 8,
    parameter int unsigned Y_BITS       = 7
) (
    input logic              clock,
    input logic              reset,
    triangle_raster_if.slave bus
);
    localparam int unsigned CW = 16;
    localparam int unsigned EW = 34;

    typedef logic signed [CW-1:0] coord_t;
    typedef logic signed [EW-1:0] acc_t;
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CLIP, S_INIT, S_SCAN, S_FLUSH, S_DONE
    } state_t;

    localparam coord_t XMAX_C = coord_t'(X_MAX);
    localparam coord_t YMAX_C = coord_t'(Y_MAX);

    state_t                  state_q, state_d;
    coord_t                  vx_q [3], vx_d [3];
    coord_t                  vy_q [3], vy_d [3];
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;
    coord_t                  xmin_q, xmin_d, xmax_q, xmax_d;
    coord_t                  ymin_q, ymin_d, ymax_q, ymax_d;
    coord_t                  x_q, x_d, y_q, y_d;
    acc_t                    e_q [3], e_d [3];
    acc_t                    erow_q [3], erow_d [3];
    acc_t                    stepx_q [3], stepx_d [3];
    acc_t                    stepy_q [3], stepy_d [3];
    logic                    plot_q, plot_d;
    logic [X_BITS-1:0]       px_q, px_d;
    logic [Y_BITS-1:0]       py_q, py_d;
    logic [COLOUR_WIDTH-1:0] pcolour_q, pcolour_d;
    logic                    draw_done_q, draw_done_d;
    logic                    busy_q, busy_d;

    logic                    advance_c, all_ge_c, all_le_c;
    acc_t                    area_c;
    logic                    unused_hi;

    assign unused_hi = ^{bus.ax[WIDTH-1:CW], bus.ay[WIDTH-1:CW], bus.bx[WIDTH-1:CW],
                         bus.by[WIDTH-1:CW], bus.cx[WIDTH-1:CW], bus.cy[WIDTH-1:CW]};

    // E_uv(q) = (vx-ux)(qy-uy) - (vy-uy)(qx-ux), exact in 34 bits for 16-bit inputs
    function automatic acc_t edge_fn(input coord_t ux, input coord_t uy, input coord_t vx,
                                     input coord_t vy, input coord_t qx, input coord_t qy);
        acc_t dx, dy;
        dx = EW'(vx) - EW'(ux);
        dy = EW'(vy) - EW'(uy);
        return dx * (EW'(qy) - EW'(uy)) - dy * (EW'(qx) - EW'(ux));
    endfunction

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    always_comb begin
        state_d     = state_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        colour_d    = colour_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymin_d      = ymin_q;
        ymax_d      = ymax_q;
        x_d         = x_q;
        y_d         = y_q;
        e_d         = e_q;
        erow_d      = erow_q;
        stepx_d     = stepx_q;
        stepy_d     = stepy_q;
        plot_d      = plot_q;
        px_d        = px_q;
        py_d        = py_q;
        pcolour_d   = pcolour_q;
        advance_c   = !plot_q || bus.plot_ready;
        area_c      = edge_fn(vx_q[0], vy_q[0], vx_q[1], vy_q[1], vx_q[2], vy_q[2]);
        all_ge_c    = 1'b1;
        all_le_c    = 1'b1;

        // Inclusive inside test accepting either winding
        for (int i = 0; i < 3; i++) begin
            if (e_q[i][EW-1]) all_ge_c = 1'b0;
            if (!e_q[i][EW-1] && e_q[i] != '0) all_le_c = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.draw_en) begin
                    vx_d[0]  = $signed(bus.ax[CW-1:0]);
                    vy_d[0]  = $signed(bus.ay[CW-1:0]);
                    vx_d[1]  = $signed(bus.bx[CW-1:0]);
                    vy_d[1]  = $signed(bus.by[CW-1:0]);
                    vx_d[2]  = $signed(bus.cx[CW-1:0]);
                    vy_d[2]  = $signed(bus.cy[CW-1:0]);
                    colour_d = bus.colour;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                xmin_d  = min3(vx_q[0], vx_q[1], vx_q[2]);
                xmax_d  = max3(vx_q[0], vx_q[1], vx_q[2]);
                ymin_d  = min3(vy_q[0], vy_q[1], vy_q[2]);
                ymax_d  = max3(vy_q[0], vy_q[1], vy_q[2]);
                state_d = (area_c == '0) ? S_DONE : S_CLIP;
            end
            S_CLIP: begin
                xmin_d  = xmin_q[CW-1] ? '0 : xmin_q;
                ymin_d  = ymin_q[CW-1] ? '0 : ymin_q;
                xmax_d  = (xmax_q > XMAX_C) ? XMAX_C : xmax_q;
                ymax_d  = (ymax_q > YMAX_C) ? YMAX_C : ymax_q;
                state_d = (xmin_d > xmax_d || ymin_d > ymax_d) ? S_DONE : S_INIT;
            end
            S_INIT: begin
                for (int i = 0; i < 3; i++) begin
                    e_d[i]     = edge_fn(vx_q[i], vy_q[i], vx_q[(i+1)%3], vy_q[(i+1)%3],
                                         xmin_q, ymin_q);
                    erow_d[i]  = e_d[i];
                    stepx_d[i] = EW'(vy_q[i]) - EW'(vy_q[(i+1)%3]);
                    stepy_d[i] = EW'(vx_q[(i+1)%3]) - EW'(vx_q[i]);
                end
                x_d     = xmin_q;
                y_d     = ymin_q;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (advance_c) begin
                    plot_d    = all_ge_c || all_le_c;
                    px_d      = x_q[X_BITS-1:0];
                    py_d      = y_q[Y_BITS-1:0];
                    pcolour_d = colour_q;
                    if (x_q == xmax_q) begin
                        if (y_q == ymax_q) begin
                            state_d = S_FLUSH;
                        end else begin
                            x_d = xmin_q;
                            y_d = y_q + coord_t'(1);
                            for (int i = 0; i < 3; i++) begin
                                erow_d[i] = erow_q[i] + stepy_q[i];
                                e_d[i]    = erow_q[i] + stepy_q[i];
                            end
                        end
                    end else begin
                        x_d = x_q + coord_t'(1);
                        for (int i = 0; i < 3; i++) e_d[i] = e_q[i] + stepx_q[i];
                    end
                end
            end
            S_FLUSH: begin
                if (advance_c) begin
                    plot_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        draw_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            vx_q        <= '{default: '0};
            vy_q        <= '{default: '0};
            colour_q    <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymin_q      <= '0;
            ymax_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            e_q         <= '{default: '0};
            erow_q      <= '{default: '0};
            stepx_q     <= '{default: '0};
            stepy_q     <= '{default: '0};
            plot_q      <= 1'b0;
            px_q        <= '0;
            py_q        <= '0;
            pcolour_q   <= '0;
            draw_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            colour_q    <= colour_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            x_q         <= x_d;
            y_q         <= y_d;
            e_q         <= e_d;
            erow_q      <= erow_d;
            stepx_q     <= stepx_d;
            stepy_q     <= stepy_d;
            plot_q      <= plot_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pcolour_q   <= pcolour_d;
            draw_done_q <= draw_done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.plot      = plot_q;
    assign bus.px        = px_q;
    assign bus.py        = py_q;
    assign bus.pcolour   = pcolour_q;
    assign bus.draw_done = draw_done_q;
    assign bus.busy      = busy_q;
endmodule
